// File: rtl/pre_read_buf.sv
// pre_read_buf: first-word-fall-through output buffer in front of a
// one-cycle-latency block RAM read port. It keeps up to three words in a
// small circular store. Requests are credit-limited, so every word that is
// in flight always has a free slot waiting for it.
module pre_read_buf #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             flush_i,
    output logic             ram_rd_o,
    input  logic             ram_en_i,
    input  logic [WIDTH-1:0] ram_dat_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] dat_o,
    input  logic             rd_i,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [3];
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             inflight_q, inflight_d;
    logic             run_q;
    logic [2:0]       credit_used;
    logic             fetch;
    logic             capture;
    logic             pop;

    // Pointer advance over the three slots; slot 2 wraps to slot 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Stored words plus the word still on its way count against the 3 slots.
    assign credit_used = {1'b0, count_q} + {2'b00, inflight_q};
    assign ram_rd_o    = run_q & ~flush_i & (credit_used < 3'd3);
    assign fetch       = ram_rd_o & ram_en_i;
    assign valid_o     = (count_q != 2'd0);
    assign dat_o       = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    // A flush discards the returning word and overrides a pop.
    assign capture     = inflight_q & ~flush_i;
    assign pop         = rd_i & valid_o & ~flush_i;

    // Next-state for pointers, occupancy and the in-flight marker.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = fetch;
        if (flush_i) begin
            wr_ptr_d   = 2'd0;
            rd_ptr_d   = 2'd0;
            count_d    = 2'd0;
            inflight_d = 1'b0;
        end else begin
            if (capture) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)     rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({capture, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers; run holds off requests until the first edge after reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            run_q      <= 1'b1;
        end
    end

    // Word store: written one cycle after a fetch; flush leaves contents alone.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < 3; i++) mem_q[i] <= '0;
        end else if (capture) begin
            mem_q[wr_ptr_q] <= ram_dat_i;
        end
    end

endmodule

// File: tb/tb_pre_read_buf.sv
// Directed bench for pre_read_buf: reset, single word, streaming,
// back-pressure with drain, protocol violation, flush and mid-stream reset.
module tb_pre_read_buf;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        ram_rd;
    logic        ram_en;
    logic [15:0] ram_dat;
    logic        valid;
    logic [15:0] dat;
    logic        rd;
    logic [1:0]  count;

    int n_checks = 0;
    int n_pass   = 0;
    int fetches;

    pre_read_buf #(.WIDTH(16)) dut (
        .clk_i     (clk),
        .reset_ni  (rst_n),
        .flush_i   (flush),
        .ram_rd_o  (ram_rd),
        .ram_en_i  (ram_en),
        .ram_dat_i (ram_dat),
        .valid_o   (valid),
        .dat_o     (dat),
        .rd_i      (rd),
        .count_o   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; inputs are then changed and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ram_en = 1'b0; ram_dat = '0; rd = 1'b0;

        // Reset and idle
        repeat (3) tick();
        chk("rst_valid", valid, 0);
        chk("rst_dat", dat, 0);
        chk("rst_count", count, 0);
        chk("rst_ram_rd", ram_rd, 0);
        rst_n = 1'b1;
        tick();
        chk("run_ram_rd", ram_rd, 1);
        chk("idle_valid", valid, 0);
        tick();
        chk("idle_valid2", valid, 0);

        // Single word
        ram_en = 1'b1;
        tick();
        ram_en = 1'b0; ram_dat = 16'hA5A5;
        #1 chk("sw_not_yet", valid, 0);
        tick();
        chk("sw_valid", valid, 1);
        chk("sw_dat", dat, 16'hA5A5);
        chk("sw_count", count, 1);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("sw_popped", valid, 0);
        chk("sw_count0", count, 0);

        // Streaming: ram_dat in cycle k carries word k
        ram_en = 1'b1; rd = 1'b1; ram_dat = '0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            ram_dat = 16'(k);
            if (k >= 2) begin
                chk("st_dat", dat, k - 1);
                chk("st_count", count, 1);
                chk("st_ram_rd", ram_rd, 1);
            end
        end
        ram_en = 1'b0;
        tick();
        chk("st_tail_dat", dat, 8);
        chk("st_tail_count", count, 1);
        ram_dat = '0;
        tick();
        chk("st_empty", valid, 0);
        rd = 1'b0;

        // Back-pressure: words 11,22,33 returned for three fetches, junk otherwise
        ram_en = 1'b1; fetches = 0;
        begin
            logic [15:0] words [3];
            logic        prev_fetch;
            words[0] = 16'h0011; words[1] = 16'h0022; words[2] = 16'h0033;
            prev_fetch = 1'b0;
            for (int c = 0; c < 6; c++) begin
                if (c > 0) tick();
                ram_dat = (prev_fetch && fetches <= 3) ? words[fetches-1] : 16'hDEAD;
                #1;
                prev_fetch = ram_rd & ram_en;
                if (prev_fetch) fetches++;
            end
        end
        chk("bp_fetches", fetches, 3);
        chk("bp_count", count, 3);
        chk("bp_ram_rd", ram_rd, 0);
        chk("bp_head", dat, 16'h0011);

        // Protocol violation: ram_en high while full must not capture
        ram_dat = 16'hDEAD;
        tick();
        tick();
        chk("pv_count", count, 3);
        chk("pv_head", dat, 16'h0011);

        // Drain in order; requests resume once count drops to 2
        rd = 1'b1;
        #1 chk("dr_ram_rd0", ram_rd, 0);
        tick();
        chk("dr_dat1", dat, 16'h0022);
        chk("dr_count1", count, 2);
        chk("dr_ram_rd1", ram_rd, 1);
        ram_en = 1'b0;
        tick();
        chk("dr_dat2", dat, 16'h0033);
        chk("dr_count2", count, 1);
        tick();
        chk("dr_empty", valid, 0);
        rd = 1'b0;

        // Flush in the cycle the fetched word returns
        ram_en = 1'b1;
        tick();
        ram_dat = 16'hBEEF; flush = 1'b1;
        #1 chk("fl_ram_rd_low", ram_rd, 0);
        tick();
        flush = 1'b0; ram_en = 1'b0;
        #1;
        chk("fl_count", count, 0);
        chk("fl_valid", valid, 0);
        chk("fl_ram_rd_back", ram_rd, 1);
        tick();
        chk("fl_no_word", valid, 0);

        // Mid-stream reset clears everything immediately
        ram_en = 1'b1; ram_dat = 16'h1234;
        tick();
        tick();
        chk("mr_before", count, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_count", count, 0);
        chk("mr_valid", valid, 0);
        chk("mr_dat", dat, 0);
        chk("mr_ram_rd", ram_rd, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
